bcd_to_bin_converter_32bit: RTL

// - Sequential BCD-to-binary converter (reverse double dabble); inverse of the 32-bit binary-to-BCD converter.
// - Takes NUM_DIGITS packed decimal digits and returns a BIN_WIDTH-bit unsigned binary value.
// - Sits on the datapath side of the numeric I/O path (decimal entry/display -> core registers).
// - Start/done handshake. One conversion in flight at a time.

---
 rtl/bcd_to_bin_converter_32bit_if.sv | 23 ++
 rtl/bcd_to_bin_converter_32bit.sv | 112 +++++++++++
 2 files changed

// File: rtl/bcd_to_bin_converter_32bit_if.sv
// Start/done handshake bundle between a requester (master) and the BCD-to-binary converter (slave).
// i_bcd[0] is the least-significant decimal digit.
interface bcd_to_bin_converter_32bit_if #(
    parameter int NUM_DIGITS = 10,
    parameter int BIN_WIDTH  = 32
);
    logic                 i_start;
    logic [3:0]           i_bcd [NUM_DIGITS-1:0];
    logic                 o_busy;
    logic                 o_done;
    logic [BIN_WIDTH-1:0] o_bin;
    logic                 o_err;

    modport master (
        output i_start, i_bcd,
        input  o_busy, o_done, o_bin, o_err
    );

    modport slave (
        input  i_start, i_bcd,
        output o_busy, o_done, o_bin, o_err
    );
endinterface

// File: rtl/bcd_to_bin_converter_32bit.sv
// Sequential BCD-to-binary converter (reverse double dabble), one conversion in flight.
// Latency: o_done pulses BIN_WIDTH+1 edges after the start edge (1 edge for a rejected input).
// No backpressure: i_start is only honoured in IDLE; optional digit check via BCD_DIGIT_CHECK_EN.
module bcd_to_bin_converter_32bit #(
    parameter int NUM_DIGITS = 10,
    parameter int BIN_WIDTH  = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    bcd_to_bin_converter_32bit_if.slave   io_bus
);
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int WORK_W = BCD_W + BIN_WIDTH;
    localparam int CNT_W  = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [WORK_W-1:0]   r_work;
    logic [CNT_W-1:0]    r_cnt;

    logic [WORK_W-1:0]   w_load;
    logic [WORK_W-1:0]   w_shift;
    logic [WORK_W-1:0]   w_next;

    always_comb begin
        w_load = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            w_load[BIN_WIDTH + 4*d +: 4] = io_bus.i_bcd[d];
        end
    end

    // Undo the doubling correction: a digit >= 8 after the shift carried in a borrowed 10, i.e. +3 too many.
    always_comb begin
        w_shift = r_work >> 1;
        w_next  = w_shift;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (w_shift[BIN_WIDTH + 4*d +: 4] >= 4'd8) begin
                w_next[BIN_WIDTH + 4*d +: 4] = w_shift[BIN_WIDTH + 4*d +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic w_bad;
    always_comb begin
        w_bad = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (io_bus.i_bcd[d] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state       <= ST_IDLE;
            r_work        <= '0;
            r_cnt         <= '0;
            io_bus.o_bin  <= '0;
            io_bus.o_err  <= 1'b0;
            io_bus.o_done <= 1'b0;
            io_bus.o_busy <= 1'b0;
        end else begin
            io_bus.o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.i_start) begin
`ifdef BCD_DIGIT_CHECK_EN
                        if (w_bad) begin
                            r_state      <= ST_DONE;
                            io_bus.o_bin <= '0;
                            io_bus.o_err <= 1'b1;
                        end else
`endif
                        begin
                            r_state       <= ST_SHIFT;
                            r_work        <= w_load;
                            r_cnt         <= '0;
                            io_bus.o_err  <= 1'b0;
                            io_bus.o_busy <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state       <= ST_DONE;
                        io_bus.o_bin  <= w_next[BIN_WIDTH-1:0];
                        // Anything left in the BCD field is the quotient by 2**BIN_WIDTH.
                        io_bus.o_err  <= |w_next[WORK_W-1:BIN_WIDTH];
                        io_bus.o_busy <= 1'b0;
                    end
                end
                ST_DONE: begin
                    io_bus.o_done <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
